cpu_test_monitor: RTL and testbench
===================================

Name: cpu_test_monitor

Overview:
Synthesizable, parametrised self-checking monitor that sits beside PipelinedCPU in simulation and FPGA bring-up. It snoops write-back and retirement, keeps a shadow register file, and detects program halt or timeout. It then checks a programmable table of expected register values and reports done, pass or fail, plus the first mismatch. It replaces hard-coded final-state checks with a reusable, cycle-counted, programmable checker.

Parameters:
XLEN, 32, data/register width
NUM_CHECKS, 8, entries in the expected-value table
MAX_CYCLES, 150, run-phase cycle budget before timeout
DRAIN_CYCLES, 4, cycles waited after halt so in-flight write-backs land
HALT_INSTR, 32'h0000006f, retired instruction that signals halt (jal x0,0)
CW, 16, width of the cycle and retire counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; leaves IDLE and begins the run
wb_we  in  1  register-file write enable at write-back
wb_rd  in  5  write-back destination register
wb_data  in  XLEN  write-back data
retire_valid  in  1  an instruction retires this cycle
retire_instr  in  32  the retiring instruction word
cfg_we  in  1  expected-table write strobe
cfg_idx  in  $clog2(NUM_CHECKS)  table entry index
cfg_valid  in  1  entry enable
cfg_reg  in  5  register to check
cfg_val  in  XLEN  expected value
busy  out  1  asserted in RUN, DRAIN and CHECK
done  out  1  sticky completion flag
pass  out  1  sticky; valid when done
timeout  out  1  sticky; run budget exhausted
cycle_count  out  CW  cycles spent in RUN
retired_count  out  CW  number of retire_valid pulses seen in RUN
mismatch_reg  out  5  register of the first failing check
mismatch_got  out  XLEN  shadow value at the first failing check

Behaviour:
- Reset (synchronous, active-high, takes priority over every other input):
  - State goes to IDLE; all outputs and counters go to 0.
  - All shadow registers go to 0.
  - The expected table is NOT cleared, so a configuration survives a re-run.
- States: IDLE, RUN, DRAIN, CHECK, DONE.
- IDLE:
  - cfg_we is honoured only in IDLE; writes in any other state are ignored.
  - On start: clear the shadow registers and counters, then go to RUN next cycle.
- Shadow register update (RUN and DRAIN only):
  - On wb_we with wb_rd != 0, shadow[wb_rd] takes wb_data at the clock edge.
  - x0 always reads 0.
- RUN:
  - cycle_count increments every cycle and saturates at its maximum.
  - retired_count increments on retire_valid.
  - retire_valid with retire_instr == HALT_INSTR: go to DRAIN.
  - Otherwise, if cycle_count == MAX_CYCLES-1: set timeout, go to DONE (no check; pass=0).
  - Halt and timeout in the same cycle: halt wins.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, then goes to CHECK.
  - Write-backs during DRAIN still update the shadow registers.
- CHECK:
  - Visits table entries 0..NUM_CHECKS-1, one per cycle; entries with valid=0 are skipped but still take their cycle.
  - On the first entry where shadow[reg] != val, latch mismatch_reg and mismatch_got; later mismatches do not overwrite them.
  - After the last entry: go to DONE with pass=1 if no mismatch was latched.
  - All entries invalid means pass=1.
  - CHECK latency is exactly NUM_CHECKS cycles.
- DONE:
  - done=1 and the outputs hold.
  - start returns to RUN (re-run), clearing done/pass/timeout/mismatch and the counters.
- start is ignored in RUN, DRAIN and CHECK.
- Reset mid-run aborts immediately to IDLE.

Decomposition:
- monitor_pkg holds:
  - the state enum type;
  - the check-entry struct {valid, reg[4:0], val[XLEN-1:0]};
  - the default HALT_INSTR constant.
- One sub-module: commit_shadow_regs
  - 32xXLEN shadow file;
  - one write port with an x0 guard;
  - one combinational read port;
  - synchronous clear input.

Test Plan:
1. Table {x1=0x12345000, x2=55}; drive write-backs x1=0x12345000, x2=55; retire 0x0000006f at cycle 40 -> done at cycle 40+DRAIN+NUM_CHECKS(+1), pass=1, timeout=0, cycle_count=41.
2. Same table, but x2 gets 54 -> pass=0, mismatch_reg=2, mismatch_got=54.
3. No halt for 150 cycles -> timeout=1, done=1, pass=0, cycle_count=150, and no CHECK cycles.
4. Write-back x3=1 two cycles after the halt retires, table x3=1 -> pass=1 (drain capture). Repeat with DRAIN_CYCLES=1 and the write-back at +3 -> pass=0.
5. wb_we to x0 with 0xDEADBEEF, table x0=0 -> pass=1. cfg_we asserted during RUN does not alter the table (verify on the next run).
6. Assert rst at cycle 20 of RUN -> IDLE next cycle, all outputs 0. Then start again -> normal completion with the preserved table.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and constants for the CPU test monitor.
// Holds the monitor state encoding, the expected-value table entry and the default halt word.
// Combinational only; no timing or backpressure of its own.
package monitor_pkg;

    // Expected values are held at a fixed width so the entry type does not depend on XLEN;
    // the monitor zero-extends both the programmed value and the shadow value to this width.
    localparam int CHK_VAL_W = 64;

    // jal x0,0 : the canonical "spin here forever" end of a test program
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_006f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } mon_state_t;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rsel;
        logic [CHK_VAL_W-1:0] val;
    } check_entry_t;

endpackage

// File: rtl/commit_shadow_regs.sv
// Shadow copy of the architectural register file, written from the snooped write-back port.
// Write lands at the clock edge; read port is combinational; x0 always reads zero.
// No backpressure: every qualified write is accepted; synchronous clear wins over a write.
module commit_shadow_regs #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_regs [32];

    // Clear the whole file, or capture one write-back (never into x0)
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == 5'd0) ? '0 : r_regs[i_raddr];

endmodule

// File: rtl/cpu_test_monitor.sv
// Self-checking monitor: shadows write-back, waits for halt or timeout, then checks a programmable table.
// Latency: halt -> done is 1 + DRAIN_CYCLES + NUM_CHECKS edges; timeout -> done on the MAX_CYCLES-th run edge.
// No backpressure: pure snooper; start is ignored while busy, table writes are ignored outside IDLE.
module cpu_test_monitor
    import monitor_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          NUM_CHECKS   = 8,
    parameter int          MAX_CYCLES   = 150,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR   = DEFAULT_HALT_INSTR,
    parameter int          CW           = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          wb_we,
    input  logic [4:0]                    wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          retire_valid,
    input  logic [31:0]                   retire_instr,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
    input  logic                          cfg_valid,
    input  logic [4:0]                    cfg_reg,
    input  logic [XLEN-1:0]               cfg_val,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [CW-1:0]                 cycle_count,
    output logic [CW-1:0]                 retired_count,
    output logic [4:0]                    mismatch_reg,
    output logic [XLEN-1:0]               mismatch_got
);

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    mon_state_t   r_state;
    mon_state_t   w_next_state;
    check_entry_t r_table [NUM_CHECKS];

    logic [CW-1:0]   r_cycle_count;
    logic [CW-1:0]   r_retired_count;
    logic [DW-1:0]   r_drain_cnt;
    logic [IW-1:0]   r_chk_idx;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;
    logic            r_mis_found;
    logic [4:0]      r_mis_reg;
    logic [XLEN-1:0] r_mis_got;

    logic            w_halt;
    logic            w_start_run;
    logic            w_timeout_hit;
    logic            w_check_last;
    logic            w_entry_bad;
    logic            w_sh_we;
    logic            w_sh_clr;
    check_entry_t    w_entry;
    logic [XLEN-1:0] w_sh_rdata;

    assign w_halt   = retire_valid && (retire_instr == HALT_INSTR);
    assign w_entry  = r_table[r_chk_idx];
    // Only a valid entry whose register disagrees with the shadow counts as a failure
    assign w_entry_bad = (r_state == ST_CHECK) && w_entry.valid &&
                         (CHK_VAL_W'(w_sh_rdata) != w_entry.val);
    // Write-backs still in flight after halt land during DRAIN, so both phases capture
    assign w_sh_we  = wb_we && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_sh_clr = rst || w_start_run;

    commit_shadow_regs #(
        .XLEN (XLEN)
    ) u_shadow (
        .i_clk   (clk),
        .i_clr   (w_sh_clr),
        .i_we    (w_sh_we),
        .i_waddr (wb_rd),
        .i_wdata (wb_data),
        .i_raddr (w_entry.rsel),
        .o_rdata (w_sh_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and one-cycle control strobes
    always_comb begin
        w_next_state  = r_state;
        w_start_run   = 1'b0;
        w_timeout_hit = 1'b0;
        w_check_last  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt beats timeout when both happen on the same cycle
                if (w_halt) begin
                    w_next_state = ST_DRAIN;
                end else if (r_cycle_count == CW'(MAX_CYCLES - 1)) begin
                    w_next_state  = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_chk_idx == IW'(NUM_CHECKS - 1)) begin
                    w_next_state = ST_DONE;
                    w_check_last = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Expected-value table: writable only while idle, deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && (r_state == ST_IDLE)) begin
            r_table[cfg_idx] <= '{valid: cfg_valid, rsel: cfg_reg, val: CHK_VAL_W'(cfg_val)};
        end
    end

    // Counters, sticky result flags and first-mismatch capture
    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
            r_drain_cnt     <= '0;
            r_chk_idx       <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_mis_found     <= 1'b0;
            r_mis_reg       <= '0;
            r_mis_got       <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    if (retire_valid && (r_retired_count != '1)) begin
                        r_retired_count <= r_retired_count + 1'b1;
                    end
                    if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                end
                ST_CHECK: begin
                    r_chk_idx <= r_chk_idx + 1'b1;
                    if (w_entry_bad && !r_mis_found) begin
                        r_mis_found <= 1'b1;
                        r_mis_reg   <= w_entry.rsel;
                        r_mis_got   <= w_sh_rdata;
                    end
                    if (w_check_last) begin
                        r_done <= 1'b1;
                        r_pass <= !(r_mis_found || w_entry_bad);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_CHECK);
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;
    assign mismatch_reg  = r_mis_reg;
    assign mismatch_got  = r_mis_got;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Bench for cpu_test_monitor: directed scenarios plus randomized programs against a reference model.
// Expected outcome per run is queued at issue; a negedge monitor pops it when done rises.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cpu_test_monitor;

    localparam int          XLEN = 32;
    localparam int          NCHK = 8;
    localparam int          MAXC = 150;
    localparam int          DRN  = 4;
    localparam int          CW   = 16;
    localparam logic [31:0] HALT = 32'h0000_006f;
    localparam int          NCYC = 172;

    logic            clk = 1'b0;
    logic            rst, start, wb_we, retire_valid, cfg_we, cfg_valid;
    logic [4:0]      wb_rd, cfg_reg;
    logic [XLEN-1:0] wb_data, cfg_val;
    logic [31:0]     retire_instr;
    logic [2:0]      cfg_idx;
    logic            busy, done, pass, timeout;
    logic [CW-1:0]   cycle_count, retired_count;
    logic [4:0]      mismatch_reg;
    logic [XLEN-1:0] mismatch_got;

    cpu_test_monitor #(
        .XLEN(XLEN), .NUM_CHECKS(NCHK), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRN),
        .HALT_INSTR(HALT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cycle_count(cycle_count), .retired_count(retired_count),
        .mismatch_reg(mismatch_reg), .mismatch_got(mismatch_got)
    );

    always #5 clk = ~clk;

    // Program stimulus, indexed by run cycle (cycle 0 is the first cycle after start is taken)
    bit          p_we [NCYC];
    logic [4:0]  p_rd [NCYC];
    logic [31:0] p_dat[NCYC];
    bit          p_rv [NCYC];
    logic [31:0] p_ri [NCYC];
    int          p_cfg_at;

    // Reference copy of the expected table and the model's final shadow file
    bit          t_v  [NCHK];
    logic [4:0]  t_r  [NCHK];
    logic [31:0] t_val[NCHK];
    logic [31:0] m_sh [32];

    typedef struct {
        bit          pass;
        bit          tmo;
        int          cyc;
        int          ret;
        int          mreg;
        logic [31:0] mgot;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // First run cycle that retires the halt word inside the budget, or -1
    function automatic int find_halt();
        for (int t = 0; t < MAXC; t++) begin
            if (p_rv[t] && (p_ri[t] == HALT)) return t;
        end
        return -1;
    endfunction

    // Final architectural state seen by the monitor: writes count up to the end of drain
    task automatic compute_shadow();
        int h;
        int last;
        h    = find_halt();
        last = (h < 0) ? MAXC - 1 : h + DRN;
        for (int i = 0; i < 32; i++) m_sh[i] = '0;
        for (int t = 0; t <= last && t < NCYC; t++) begin
            if (p_we[t] && (p_rd[t] != 5'd0)) m_sh[p_rd[t]] = p_dat[t];
        end
    endtask

    task automatic push_expect();
        exp_t e;
        int   h;
        bit   found;
        compute_shadow();
        h      = find_halt();
        e.tmo  = (h < 0);
        e.cyc  = e.tmo ? MAXC : h + 1;
        e.lat  = e.tmo ? MAXC : h + 1 + DRN + NCHK;
        e.ret  = 0;
        for (int t = 0; t < e.cyc; t++) if (p_rv[t]) e.ret++;
        found  = 1'b0;
        e.mreg = 0;
        e.mgot = '0;
        if (!e.tmo) begin
            for (int i = 0; i < NCHK; i++) begin
                if (t_v[i] && !found && (m_sh[t_r[i]] != t_val[i])) begin
                    found  = 1'b1;
                    e.mreg = int'(t_r[i]);
                    e.mgot = m_sh[t_r[i]];
                end
            end
        end
        e.pass = !e.tmo && !found;
        sbq.push_back(e);
    endtask

    task automatic clear_prog();
        for (int t = 0; t < NCYC; t++) begin
            p_we[t] = 1'b0; p_rd[t] = '0; p_dat[t] = '0; p_rv[t] = 1'b0; p_ri[t] = '0;
        end
        p_cfg_at = -1;
    endtask

    // Background traffic: random write-backs into [lo,hi] and random non-halt retirements
    task automatic noise_prog(input int pct, input int lo, input int hi);
        logic [31:0] r;
        for (int t = 0; t < NCYC; t++) begin
            p_we[t]  = (int'($urandom_range(0, 99)) < pct);
            p_rd[t]  = 5'($urandom_range(lo, hi));
            p_dat[t] = $urandom;
            p_rv[t]  = (int'($urandom_range(0, 99)) < pct);
            r        = $urandom;
            if (r == HALT) r = r ^ 32'h1;
            p_ri[t]  = r;
        end
        p_cfg_at = -1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        retire_valid = 1'b0; retire_instr = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_reg = '0; cfg_val = '0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},    64'(busy),          64'd0);
        chk({tag, "_done"},    64'(done),          64'd0);
        chk({tag, "_pass"},    64'(pass),          64'd0);
        chk({tag, "_timeout"}, 64'(timeout),       64'd0);
        chk({tag, "_cycles"},  64'(cycle_count),   64'd0);
        chk({tag, "_retired"}, 64'(retired_count), 64'd0);
        chk({tag, "_mreg"},    64'(mismatch_reg),  64'd0);
        chk({tag, "_mgot"},    64'(mismatch_got),  64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("reset");
    endtask

    task automatic write_table();
        for (int i = 0; i < NCHK; i++) begin
            @(posedge clk); #1;
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_valid = t_v[i]; cfg_reg = t_r[i]; cfg_val = t_val[i];
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Pulse start, then play the program; optionally assert reset in place of cycle abort_at
    task automatic run_prog(input int abort_at);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int t = 0; t < NCYC; t++) begin
            if (t == abort_at) begin
                idle_inputs();
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                break;
            end
            wb_we = p_we[t]; wb_rd = p_rd[t]; wb_data = p_dat[t];
            retire_valid = p_rv[t]; retire_instr = p_ri[t];
            if (t == p_cfg_at) begin
                cfg_we = 1'b1; cfg_idx = 3'd1; cfg_valid = 1'b1; cfg_reg = 5'd5; cfg_val = 32'h777;
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        if (abort_at < 0) begin
            @(negedge clk);
            chk("done_reached", 64'(done), 64'd1);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < NCHK; i++) begin
            t_v[i] = 1'b0; t_r[i] = '0; t_val[i] = '0;
        end
    endtask

    // Monitor: count busy cycles per run and score the result when done rises
    initial begin
        bit   prev_done;
        int   busy_cnt;
        exp_t e;
        prev_done = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (done && !prev_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("pass",          64'(pass),          64'(e.pass));
                    chk("timeout",       64'(timeout),       64'(e.tmo));
                    chk("cycle_count",   64'(cycle_count),   64'(e.cyc));
                    chk("retired_count", 64'(retired_count), 64'(e.ret));
                    chk("mismatch_reg",  64'(mismatch_reg),  64'(e.mreg));
                    chk("mismatch_got",  64'(mismatch_got),  64'(e.mgot));
                    chk("busy_latency",  64'(busy_cnt),      64'(e.lat));
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Halt at cycle 40 with matching x1/x2
        clear_table();
        t_v[0] = 1'b1; t_r[0] = 5'd1; t_val[0] = 32'h1234_5000;
        t_v[1] = 1'b1; t_r[1] = 5'd2; t_val[1] = 32'd55;
        write_table();
        noise_prog(30, 8, 15);
        p_we[5]  = 1'b1; p_rd[5]  = 5'd1; p_dat[5]  = 32'h1234_5000;
        p_we[10] = 1'b1; p_rd[10] = 5'd2; p_dat[10] = 32'd55;
        p_rv[40] = 1'b1; p_ri[40] = HALT;
        push_expect();
        run_prog(-1);

        // Re-run from DONE: x2 gets 54
        p_dat[10] = 32'd54;
        push_expect();
        run_prog(-1);

        // Re-run with no halt: timeout
        p_rv[40] = 1'b0;
        push_expect();
        run_prog(-1);

        // Drain capture: last drain cycle captured, first cycle after drain missed
        do_reset();
        clear_table();
        t_v[3] = 1'b1; t_r[3] = 5'd3; t_val[3] = 32'd1;
        write_table();
        noise_prog(30, 8, 15);
        p_rv[30] = 1'b1; p_ri[30] = HALT;
        p_we[32] = 1'b1; p_rd[32] = 5'd3; p_dat[32] = 32'd1;
        p_we[34] = 1'b1; p_rd[34] = 5'd3; p_dat[34] = 32'd1;
        push_expect();
        run_prog(-1);
        p_we[32] = 1'b0; p_we[34] = 1'b0;
        p_we[35] = 1'b1; p_rd[35] = 5'd3; p_dat[35] = 32'd1;
        push_expect();
        run_prog(-1);

        // x0 write ignored; table write during RUN ignored (seen on the re-run)
        do_reset();
        clear_table();
        t_v[0] = 1'b1; t_r[0] = 5'd0; t_val[0] = 32'd0;
        write_table();
        noise_prog(30, 8, 15);
        p_we[5]  = 1'b1; p_rd[5] = 5'd0; p_dat[5] = 32'hDEAD_BEEF;
        p_rv[20] = 1'b1; p_ri[20] = HALT;
        p_cfg_at = 10;
        push_expect();
        run_prog(-1);
        push_expect();
        run_prog(-1);

        // Reset mid-run, then a clean run with the preserved table
        do_reset();
        p_cfg_at = -1;
        run_prog(20);
        check_zero("abort");
        push_expect();
        run_prog(-1);

        // Randomized programs and tables
        for (int r = 0; r < 6; r++) begin
            int h;
            do_reset();
            noise_prog(40, 1, 7);
            h = int'($urandom_range(5, 165));
            p_rv[h] = 1'b1; p_ri[h] = HALT;
            compute_shadow();
            for (int i = 0; i < NCHK; i++) begin
                t_v[i]   = ($urandom_range(0, 3) != 0);
                t_r[i]   = 5'($urandom_range(0, 7));
                t_val[i] = ($urandom_range(0, 3) != 0) ? m_sh[t_r[i]] : $urandom;
            end
            write_table();
            push_expect();
            run_prog(-1);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
